// File: rtl/tdc_capture_stats.sv
// Back end for the delay-line TDC macros: thermometer decode plus averaged statistics.
`timescale 1ns/1ps
module tdc_capture_stats #(
  parameter int unsigned DATA_WIDTH = 252,
  parameter int unsigned CODE_WIDTH = $clog2(DATA_WIDTH + 1),
  parameter int unsigned MAX_LOG2   = 4,
  parameter int unsigned LOG2_W     = $clog2(MAX_LOG2 + 1),
  parameter int unsigned ACC_WIDTH  = CODE_WIDTH + MAX_LOG2
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  start,
  input  logic [LOG2_W-1:0]     log2_samples,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ACC_WIDTH-1:0]  result_sum,
  output logic [CODE_WIDTH-1:0] result_avg,
  output logic [CODE_WIDTH-1:0] result_min,
  output logic [CODE_WIDTH-1:0] result_max,
  output logic [MAX_LOG2:0]     bubble_count,
  output logic [MAX_LOG2:0]     sat_count
);

  localparam int unsigned CNT_W = MAX_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                state, next_state;
  logic                  busy_d, result_valid_d;
  logic [LOG2_W-1:0]     n_log2, log2_clamp_c;
  logic [CNT_W-1:0]      count, n_target_c;
  logic                  start_c, accept_c, last_c;
  logic [CODE_WIDTH-1:0] code_c;
  logic                  bubble_c, sat_c;
  logic                  s1_valid, s1_bubble, s1_sat;
  logic [CODE_WIDTH-1:0] s1_code;
  logic [ACC_WIDTH-1:0]  sum_next_c;

  // Thermometer decode: popcount tolerates bubbles; bubble flags any non-thermometer word
  always_comb begin
    code_c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      code_c = code_c + CODE_WIDTH'(sample_data[i]);
    end
    bubble_c = ((sample_data + DATA_WIDTH'(1)) & sample_data) != '0;
    sat_c    = (code_c == '0) || (code_c == CODE_WIDTH'(DATA_WIDTH));
  end

  // Sample-count control and accept qualification
  always_comb begin
    log2_clamp_c = (log2_samples > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : log2_samples;
    n_target_c   = CNT_W'(1) << n_log2;
    start_c      = (state == IDLE) && start;
    accept_c     = (state == ACCUM) && sample_valid && (count < n_target_c);
    last_c       = accept_c && ((count + CNT_W'(1)) == n_target_c);
    sum_next_c   = result_sum + ACC_WIDTH'(s1_code);
  end

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (last_c) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    if (result_valid && result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; result_valid rises one cycle after DONE is entered
  always_comb begin
    busy_d         = (next_state == ACCUM) || (next_state == DRAIN);
    result_valid_d = (state == DONE) && !(result_valid && result_ready);
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      busy         <= busy_d;
      result_valid <= result_valid_d;
    end
  end

  // Stage 1: capture decoded sample and count accepted samples
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s1_valid  <= 1'b0;
      s1_code   <= '0;
      s1_bubble <= 1'b0;
      s1_sat    <= 1'b0;
      count     <= '0;
      n_log2    <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_code   <= code_c;
        s1_bubble <= bubble_c;
        s1_sat    <= sat_c;
      end
      if (start_c) begin
        count  <= '0;
        n_log2 <= log2_clamp_c;
      end else if (accept_c) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Stage 2: accumulate statistics; results hold until the next accepted start
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      result_sum   <= '0;
      result_avg   <= '0;
      result_min   <= '0;
      result_max   <= '0;
      bubble_count <= '0;
      sat_count    <= '0;
    end else if (start_c) begin
      result_sum   <= '0;
      result_avg   <= '0;
      result_min   <= CODE_WIDTH'(DATA_WIDTH);
      result_max   <= '0;
      bubble_count <= '0;
      sat_count    <= '0;
    end else if (s1_valid) begin
      result_sum   <= sum_next_c;
      result_avg   <= CODE_WIDTH'(sum_next_c >> n_log2);
      if (s1_code < result_min) result_min <= s1_code;
      if (s1_code > result_max) result_max <= s1_code;
      bubble_count <= bubble_count + CNT_W'(s1_bubble);
      sat_count    <= sat_count + CNT_W'(s1_sat);
    end
  end

endmodule
